// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle packed-BCD to unsigned binary converter, one digit per clock, valid/ready on both sides.
// Optional macro BCD_CHECK_EN adds detection of nibbles greater than 9 (reported on err).
module bcd_to_binary_seq #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);
    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [IN_W-1:0]   shift_reg;
    logic [BIN_W-1:0]  acc_reg;
    logic [BIN_W-1:0]  bin_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              out_valid_reg;

    logic [3:0]        nibble;
    logic [BIN_W-1:0]  acc_next;
    logic              last_digit;

    // Most significant digit enters first; acc*10 built from two shifts.
    assign nibble     = shift_reg[IN_W-1 -: 4];
    assign acc_next   = (acc_reg << 3) + (acc_reg << 1) + {{(BIN_W-4){1'b0}}, nibble};
    assign last_digit = (cnt_reg == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            acc_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bcd_in;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    acc_reg   <= acc_next;
                    shift_reg <= {shift_reg[IN_W-5:0], 4'b0000};
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_digit) begin
                        bin_reg       <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign bin_out   = bin_reg;
    assign out_valid = out_valid_reg;

`ifdef BCD_CHECK_EN
    logic err_flag_reg;
    logic err_reg;
    logic nibble_bad;

    assign nibble_bad = (nibble > 4'd9);

    // Flag accumulates over the digits; err is captured on entry to DONE and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && in_valid) begin
                err_flag_reg <= 1'b0;
            end else if (state_reg == CONV) begin
                err_flag_reg <= err_flag_reg | nibble_bad;
                if (last_digit) begin
                    err_reg <= err_flag_reg | nibble_bad;
                end
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
